// File: rtl/product_display_pkg.sv
// product_display_pkg
// Shared definitions for the product display path: the converter FSM state
// encoding, magnitude/BCD geometry and the double-dabble adjust constants.
// No ports (package).
package product_display_pkg;

  // Converter control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAG_WIDTH         = 12;
  localparam int BCD_DIGITS        = 4;
  localparam int BCD_WIDTH         = 4 * BCD_DIGITS;
  localparam int REG_WIDTH         = BCD_WIDTH + MAG_WIDTH;
  localparam int CNT_WIDTH         = 4;
  localparam int BCD_ADJ_THRESHOLD = 5;
  localparam int BCD_ADJ_VALUE     = 3;

  // Assemble the 12-bit magnitude from the three product terms
  function automatic logic [MAG_WIDTH-1:0] pack_magnitude(
    input logic [3:0] term3,
    input logic [3:0] term2,
    input logic [3:0] term1
  );
    return {term3, term2, term1};
  endfunction

endpackage

// File: rtl/product_bcd_converter_add3.sv
// bcd_add3_digit
// Combinational double-dabble correction for one BCD nibble: a digit of 5 or
// more gets 3 added so that the following left shift carries into the next
// decimal digit.
// Ports:
//   digit_in  [3:0]  BCD nibble before correction
//   digit_out [3:0]  corrected nibble
module bcd_add3_digit
  import product_display_pkg::*;
(
  input  logic [3:0] digit_in,
  output logic [3:0] digit_out
);

  // Add-3 correction when the nibble would overflow a decimal digit after doubling
  always_comb begin
    digit_out = digit_in;
    if (digit_in >= 4'(BCD_ADJ_THRESHOLD)) begin
      digit_out = digit_in + 4'(BCD_ADJ_VALUE);
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter
// Accepts a sign-magnitude product (sign + three 4-bit terms forming a 12-bit
// magnitude), converts the magnitude to four BCD digits with a bit-serial
// shift-add-3 loop (one bit per clock) and presents the result behind a
// valid/ready handshake.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        upstream handshake (ready only in IDLE)
//   in_sign, in_term3..1       product sign and magnitude nibbles
//   out_valid / out_ready      downstream handshake (valid only in DONE)
//   out_sign                   result sign (negative zero optionally cleared)
//   out_thousands..out_ones    BCD result digits
module product_bcd_converter
  import product_display_pkg::*;
#(
  parameter bit SUPPRESS_NEG_ZERO = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_sign,
  input  logic [3:0] in_term1,
  input  logic [3:0] in_term2,
  input  logic [3:0] in_term3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sign,
  output logic [3:0] out_thousands,
  output logic [3:0] out_hundreds,
  output logic [3:0] out_tens,
  output logic [3:0] out_ones
);

  // One iteration per magnitude bit; tied to the magnitude width.
  localparam int SHIFT_CYCLES = MAG_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(SHIFT_CYCLES - 1);

  state_t                 state;
  state_t                 next_state;
  logic [CNT_WIDTH-1:0]   iter_count;
  logic [REG_WIDTH-1:0]   shift_reg;
  logic                   sign_lat;
  logic                   mag_zero;
  logic [BCD_WIDTH-1:0]   bcd_adj;
  logic [REG_WIDTH-1:0]   adj_reg;
  logic [REG_WIDTH-1:0]   shift_next;
  logic [MAG_WIDTH-1:0]   in_mag;
  logic                   last_iter;

  assign in_mag    = pack_magnitude(in_term3, in_term2, in_term1);
  assign last_iter = (iter_count == LAST_ITER);

  // Correct each BCD nibble of the working register before the shift
  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    bcd_add3_digit u_adj (
      .digit_in  (shift_reg[MAG_WIDTH + 4*g +: 4]),
      .digit_out (bcd_adj[4*g +: 4])
    );
  end

  // Corrected BCD field on top of the untouched binary field, then shift
  // left one. The top bit shifted out is always 0 because 4095 < 5000.
  assign adj_reg    = {bcd_adj, shift_reg[MAG_WIDTH-1:0]};
  assign shift_next = adj_reg << 1;

  // Handshake flags decode straight from the state register
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = SHIFT;
        end else begin
          next_state = IDLE;
        end
      end
      SHIFT: begin
        if (last_iter) begin
          next_state = DONE;
        end else begin
          next_state = SHIFT;
        end
      end
      DONE: begin
        if (out_ready) begin
          next_state = IDLE;
        end else begin
          next_state = DONE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Conversion datapath and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_count    <= '0;
      shift_reg     <= '0;
      sign_lat      <= 1'b0;
      mag_zero      <= 1'b0;
      out_sign      <= 1'b0;
      out_thousands <= 4'd0;
      out_hundreds  <= 4'd0;
      out_tens      <= 4'd0;
      out_ones      <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_reg  <= {{BCD_WIDTH{1'b0}}, in_mag};
            sign_lat   <= in_sign;
            mag_zero   <= (in_mag == {MAG_WIDTH{1'b0}});
            iter_count <= '0;
          end
        end
        SHIFT: begin
          shift_reg  <= shift_next;
          iter_count <= iter_count + CNT_WIDTH'(1);
          if (last_iter) begin
            // Digits come from the register value after the final shift;
            // no correction is applied after it.
            out_thousands <= shift_next[MAG_WIDTH + 12 +: 4];
            out_hundreds  <= shift_next[MAG_WIDTH + 8  +: 4];
            out_tens      <= shift_next[MAG_WIDTH + 4  +: 4];
            out_ones      <= shift_next[MAG_WIDTH      +: 4];
            out_sign      <= sign_lat & ~(SUPPRESS_NEG_ZERO & mag_zero);
          end
        end
        DONE: begin
          // Result held until the downstream handshake
        end
        default: begin
          iter_count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter
// Self-checking bench: two converters (negative-zero suppression on and off)
// share one stimulus stream. Expected digits come from decimal arithmetic on
// the magnitude; a compare process checks every cycle a result is valid.
module tb_product_bcd_converter;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_sign;
  logic [3:0] in_term1;
  logic [3:0] in_term2;
  logic [3:0] in_term3;
  logic       out_ready;

  logic       in_ready, out_valid, out_sign;
  logic [3:0] out_thousands, out_hundreds, out_tens, out_ones;
  logic       nz_in_ready, nz_out_valid, nz_out_sign;
  logic [3:0] nz_thousands, nz_hundreds, nz_tens, nz_ones;

  int checks = 0;
  int errors = 0;

  int exp_mag  = 0;
  bit exp_sign = 1'b0;

  product_bcd_converter #(.SUPPRESS_NEG_ZERO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_term1(in_term1), .in_term2(in_term2), .in_term3(in_term3),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign),
    .out_thousands(out_thousands), .out_hundreds(out_hundreds),
    .out_tens(out_tens), .out_ones(out_ones)
  );

  product_bcd_converter #(.SUPPRESS_NEG_ZERO(1'b0)) dut_nz (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(nz_in_ready),
    .in_sign(in_sign), .in_term1(in_term1), .in_term2(in_term2), .in_term3(in_term3),
    .out_valid(nz_out_valid), .out_ready(out_ready), .out_sign(nz_out_sign),
    .out_thousands(nz_thousands), .out_hundreds(nz_hundreds),
    .out_tens(nz_tens), .out_ones(nz_ones)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal reference: digits straight from division and remainder
  function automatic logic [15:0] model_bcd(input int m);
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every valid cycle must match the reference
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      check("digits", {16'd0, out_thousands, out_hundreds, out_tens, out_ones},
            {16'd0, model_bcd(exp_mag)});
      check("sign", {31'd0, out_sign}, {31'd0, exp_sign & (exp_mag != 0)});
    end
    if (nz_out_valid === 1'b1) begin
      check("nz_digits", {16'd0, nz_thousands, nz_hundreds, nz_tens, nz_ones},
            {16'd0, model_bcd(exp_mag)});
      check("nz_sign", {31'd0, nz_out_sign}, {31'd0, exp_sign});
    end
  end

  // One full transaction: offer, count latency, stall, handshake
  task automatic do_txn(input int mag, input bit sgn, input int stall, input bit noise);
    logic [11:0] m12;
    int guard;
    int edges;
    m12   = mag[11:0];
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("ready_before", {31'd0, in_ready}, 32'd1);
    exp_mag  = mag;
    exp_sign = sgn;
    in_valid = 1'b1;
    in_sign  = sgn;
    in_term1 = m12[3:0];
    in_term2 = m12[7:4];
    in_term3 = m12[11:8];
    @(negedge clk);
    edges    = 1;
    in_valid = noise;
    if (noise) begin
      in_sign  = 1'($urandom_range(0, 1));
      in_term1 = 4'($urandom_range(0, 15));
    end
    check("ready_shift", {31'd0, in_ready}, 32'd0);
    while (out_valid !== 1'b1 && edges < 20) begin
      @(negedge clk);
      edges++;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_term2 = 4'($urandom_range(0, 15));
        in_term3 = 4'($urandom_range(0, 15));
      end
    end
    check("latency", edges, 32'd13);
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      if (noise) in_valid = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop", {31'd0, out_valid}, 32'd0);
    check("ready_back", {31'd0, in_ready}, 32'd1);
    check("nz_ready_back", {31'd0, nz_in_ready}, 32'd1);
  endtask

  task automatic check_result(input string name, input logic [15:0] digits, input bit sgn);
    check(name, {16'd0, out_thousands, out_hundreds, out_tens, out_ones}, {16'd0, digits});
    check({name, "_sign"}, {31'd0, out_sign}, {31'd0, sgn});
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog expired actual running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int mag;
    int boundary [9] = '{0, 1, 9, 10, 99, 100, 999, 1000, 4095};
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_term1  = 4'd0;
    in_term2  = 4'd0;
    in_term3  = 4'd0;
    out_ready = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    check_result("rst_out", 16'h0000, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", {31'd0, in_ready}, 32'd1);

    // 15*15 = 225
    do_txn(12'h0E1, 1'b0, 0, 1'b0);
    check_result("lit_225", 16'h0225, 1'b0);
    // Maximum magnitude, negative
    do_txn(12'hFFF, 1'b1, 2, 1'b0);
    check_result("lit_4095", 16'h4095, 1'b1);
    // Negative zero
    do_txn(12'h000, 1'b1, 1, 1'b0);
    check_result("lit_negzero", 16'h0000, 1'b0);
    check("lit_negzero_nz", {31'd0, nz_out_sign}, 32'd1);
    // 123 with 5 stall cycles and ignored upstream noise
    do_txn(12'h07B, 1'b0, 5, 1'b1);
    check_result("lit_123", 16'h0123, 1'b0);

    // Asynchronous reset mid-conversion
    while (in_ready !== 1'b1) @(negedge clk);
    exp_mag  = 12'h3A7;
    exp_sign = 1'b1;
    in_valid = 1'b1;
    in_sign  = 1'b1;
    in_term1 = 4'h7;
    in_term2 = 4'hA;
    in_term3 = 4'h3;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check_result("abort_out", 16'h0000, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'd0, in_ready}, 32'd1);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("abort_no_result", {31'd0, out_valid}, 32'd0);
    end
    do_txn(12'h100, 1'b0, 0, 1'b0);
    check_result("lit_256", 16'h0256, 1'b0);

    // Decimal boundaries, both signs
    for (int i = 0; i < 9; i++) begin
      do_txn(boundary[i], 1'b0, 0, 1'b0);
      do_txn(boundary[i], 1'b1, 1, 1'b1);
    end

    // Randomised sweep
    for (int i = 0; i < 2400; i++) begin
      mag = int'($urandom_range(0, 4095));
      do_txn(mag, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
